key_event_collector: RTL
========================

// Module: key_event_collector
// PURPOSE
//   I/O-clock-domain front end for the keypad status register: synchronises and debounces NUM_KEYS raw
//   key inputs, detects press (and optionally release) events and pushes status words into the
//   read-clear register's IO write port, respecting its IO_Busy handshake.
//   Word layout: [N-1:0] debounced levels, [2N-1:N] press events, [3N-1:2N] release events (N=NUM_KEYS).
//   Downstream register uses CLEAR_MASK = events-only, so levels persist across processor reads.
// PARAMETERS
//   NUM_KEYS        4       number of key inputs (1..10)
//   DEBOUNCE_CYCLES 50000   consecutive stable cycles required to accept a new level (>=2)
//   ACTIVE_LOW      1       1: raw input low = pressed; 0: high = pressed
//   DATA_WIDTH      32      width of IO_WrData; must be >= 3*NUM_KEYS
// PORTS
//   Clock     in   1           I/O clock; single clock domain
//   Reset     in   1           asynchronous, active-high
//   KeyRaw    in   NUM_KEYS    raw asynchronous key pins
//   IO_Busy   in   1           from register handshake; high while a transfer is in flight
//   IO_WrData out  DATA_WIDTH  status word to register
//   IO_WrEn   out  1           one-cycle write strobe
//   KeyLevel  out  NUM_KEYS    debounced pressed levels (1 = pressed), for local use
// BEHAVIOUR
//   Reset: IO_WrEn=0, IO_WrData=0, KeyLevel=0, pending events=0, FSM=IDLE, counters=0; sync FFs = released.
//   Per key: 2-FF synchroniser, polarity normalised; counter clears when synced==level, else increments;
//     on reaching DEBOUNCE_CYCLES-1 level flips and counter clears. Accept latency = 2 + DEBOUNCE_CYCLES.
//   Level 0->1 sets pending press bit; 1->0 sets pending release bit (release only if macro defined).
//   Pending bits are sticky-OR; multiple presses before a send merge into one bit.
//   FSM: IDLE  -> SEND when (pending != 0) and IO_Busy=0.
//        SEND  : IO_WrEn=1 for exactly one cycle; IO_WrData = {0, rel, press, KeyLevel} snapshot;
//                pending cleared except events detected in this same cycle (they stay pending); -> GUARD.
//        GUARD : one cycle, IO_WrEn=0 (covers IO_Busy assertion latency of 1 cycle); -> WAIT.
//        WAIT  : stay while IO_Busy=1; -> IDLE when IO_Busy=0.
//   IO_WrData is registered, held stable from SEND until next SEND. Unused upper bits always 0.
//   IO_WrEn never asserted while IO_Busy=1 or in GUARD/WAIT; min spacing between strobes = 3 cycles.
//   Simultaneous press on several keys in one cycle -> single word with all bits set.
//   Glitch shorter than DEBOUNCE_CYCLES: no level change, no event.
//   Reset mid-transfer: all state returns to reset values; an in-flight word may be lost (accepted).
// CONFIGURATION
//   KEY_EVENT_RELEASE_EN defined: release events tracked and placed in [3N-1:2N].
//   Not defined: release bits constant 0, no release pending logic; a release alone never triggers SEND
//     (KeyLevel in the register updates with the next press word).
// STRUCTURE
//   Package key_event_pkg: typedef enum {IDLE, SEND, GUARD, WAIT} kec_state_t; localparams for field
//     offsets (LEVEL_LSB=0, PRESS_LSB=N, RELEASE_LSB=2N) as functions of NUM_KEYS.
//   Sub-module key_debouncer (one instance per key via generate): sync + counter + level + rise/fall pulses.
//   Top: pending vectors, FSM, output register.
// TESTING (DEBOUNCE_CYCLES=8, NUM_KEYS=4, ACTIVE_LOW=1 for bench)
//   Reset asserted mid-count -> all outputs 0 immediately (async), no IO_WrEn after release of Reset.
//   KeyRaw[1] low for 5 cycles then high -> no level change, IO_WrEn never asserted.
//   KeyRaw[2] held low -> KeyLevel[2]=1 after 10 cycles; one IO_WrEn with IO_WrData=32'h0000_0044.
//   Press key0 while IO_Busy held high 20 cycles -> no strobe until IO_Busy=0, then word 32'h0000_0011.
//   Press key3 during WAIT of key0 transfer -> second strobe after IO_Busy falls, data 32'h0000_0089.
//   With KEY_EVENT_RELEASE_EN: release key2 (after press) -> word 32'h0000_0400; without: no strobe.

Source files
------------

// File: rtl/key_event_collector_pkg.sv
// Shared types and field offsets for the keypad event collector.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package key_event_pkg;

    // Collector handshake sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GUARD,
        WAIT
    } kec_state_t;

    // Status word layout: levels at bit 0, then press events, then release events.
    localparam int LEVEL_LSB = 0;

    function automatic int press_lsb(input int num_keys);
        return num_keys;
    endfunction

    function automatic int release_lsb(input int num_keys);
        return 2 * num_keys;
    endfunction

endpackage

// File: rtl/key_event_collector_if.sv
// Write port towards the read-clear keypad status register.
// Latency: n/a (wires only); the register raises io_busy one cycle after io_wr_en.
// Backpressure: io_busy high means a transfer is in flight and no new strobe may be issued.
// Signals: io_wr_dat status word, io_wr_en one-cycle write strobe, io_busy handshake from the register.
interface key_event_collector_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] io_wr_dat;
    logic                  io_wr_en;
    logic                  io_busy;

    modport master (output io_wr_dat, output io_wr_en, input io_busy);
    modport slave  (input io_wr_dat, input io_wr_en, output io_busy);
endinterface

// File: rtl/key_event_collector_debouncer.sv
// Per-key 2-FF synchroniser, polarity normalisation and debounce counter.
// Latency: a stable new pin level is accepted 2 + DEBOUNCE_CYCLES cycles after it appears.
// Backpressure: none; free-running, flip_o is a single-cycle pulse on the edge that updates level_o.
// Ports: clk, rst (async, active-high), key_raw_i raw pin, level_o debounced pressed level (1 = pressed),
//        flip_o high in the cycle whose clock edge toggles level_o.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw_i,
    output logic level_o,
    output logic flip_o
);
    localparam int   CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic IDLE_RAW = (ACTIVE_LOW != 0);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed;
    logic             flip;

    // Synchroniser resets to the pin's released level so no spurious press follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= IDLE_RAW;
            sync2_q <= IDLE_RAW;
        end else begin
            sync1_q <= key_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = sync2_q ^ IDLE_RAW;

    // Counter tracks how many consecutive cycles the synced input has disagreed with the
    // accepted level; any agreeing cycle restarts it, so short glitches never flip the level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        flip    = 1'b0;
        if (pressed == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = ~level_q;
            flip    = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    assign flip_o  = flip;
endmodule

// File: rtl/key_event_collector.sv
// Keypad front end: debounces NUM_KEYS pins, collects press (and with KEY_EVENT_RELEASE_EN, release) events, writes status words.
// Latency: key accepted 2 + DEBOUNCE_CYCLES cycles after the pin settles; strobe follows one cycle after pending is seen with io_busy low.
// Backpressure: strobes only from IDLE with io_busy low; then one GUARD cycle and WAIT until io_busy drops; events accumulate meanwhile.
// Ports: clk, rst (async, active-high), key_raw_i raw pins, key_level_o debounced levels, io (master) write port.
// Word: [N-1:0] levels, [2N-1:N] press events, [3N-1:2N] release events (zero unless KEY_EVENT_RELEASE_EN), upper bits zero.
module key_event_collector
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw_i,
    output logic [NUM_KEYS-1:0] key_level_o,
    key_event_collector_if.master io
);
    localparam int PRESS_LSB   = press_lsb(NUM_KEYS);
    localparam int RELEASE_LSB = release_lsb(NUM_KEYS);

    if (DATA_WIDTH < 3 * NUM_KEYS) begin : g_cfg_err
        $error("DATA_WIDTH must hold levels, press and release fields");
    end

    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] flip;
    logic [NUM_KEYS-1:0] rise;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_deb (
            .clk       (clk),
            .rst       (rst),
            .key_raw_i (key_raw_i[k]),
            .level_o   (level[k]),
            .flip_o    (flip[k])
        );
    end

    // flip is seen before level updates, so the current level tells the direction.
    assign rise = flip & ~level;

    kec_state_t            state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] wr_dat_q, wr_dat_d;
    logic [DATA_WIDTH-1:0] word;
    logic                  send;
    logic                  pending_any;
    logic [NUM_KEYS-1:0]   press_pend_q, press_pend_d;
    logic [NUM_KEYS-1:0]   rel_pend;

`ifdef KEY_EVENT_RELEASE_EN
    logic [NUM_KEYS-1:0] fall;
    logic [NUM_KEYS-1:0] rel_pend_q, rel_pend_d;

    assign fall     = flip & level;
    assign rel_pend = rel_pend_q;

    always_comb begin
        rel_pend_d = send ? fall : (rel_pend_q | fall);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rel_pend_q <= '0;
        end else begin
            rel_pend_q <= rel_pend_d;
        end
    end
`else
    assign rel_pend = '0;
`endif

    assign pending_any = (|press_pend_q) | (|rel_pend);

    // Snapshot of what the register should see: current levels plus events gathered so far.
    always_comb begin
        word                            = '0;
        word[LEVEL_LSB +: NUM_KEYS]     = level;
        word[PRESS_LSB +: NUM_KEYS]     = press_pend_q;
        word[RELEASE_LSB +: NUM_KEYS]   = rel_pend;
    end

    // Sticky pending bits. On the send edge the snapshot leaves, but events detected in
    // that very cycle were not in it, so they become the new pending set.
    always_comb begin
        press_pend_d = send ? rise : (press_pend_q | rise);
    end

    always_comb begin
        state_d  = state_q;
        wr_en_d  = 1'b0;
        wr_dat_d = wr_dat_q;
        send     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_any && !io.io_busy) begin
                    state_d  = SEND;
                    wr_en_d  = 1'b1;
                    wr_dat_d = word;
                    send     = 1'b1;
                end
            end
            SEND:    state_d = GUARD;
            // io_busy rises one cycle after the strobe; this cycle lets it become visible.
            GUARD:   state_d = WAIT;
            WAIT: begin
                if (!io.io_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_en_q      <= 1'b0;
            wr_dat_q     <= '0;
            press_pend_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            wr_dat_q     <= wr_dat_d;
            press_pend_q <= press_pend_d;
        end
    end

    assign io.io_wr_en  = wr_en_q;
    assign io.io_wr_dat = wr_dat_q;
    assign key_level_o  = level;
endmodule
